// File: rtl/rgb_key_ctrl.sv
// -----------------------------------------------------------------------------
// rgb_key_ctrl
// Control stage for the rainbow breathing light. Debounces the speed and mode
// push-buttons, keeps the breathing-speed index and the display mode, and
// produces the duty-step strobe that paces the PWM ramp generators.
//
// Ports
//   i_clk         system clock, all logic on the rising edge
//   i_rst         synchronous reset, active high
//   i_key_spd_n   raw speed button, active low, asynchronous
//   i_key_mode_n  raw mode button, active low, asynchronous
//   o_speed       speed index, 0 = slowest .. 3 = fastest
//   o_mode        00 rainbow, 01 single LED, 10 dual LED sync
//   o_step_tick   one-cycle duty-step strobe
//   o_spd_evt     one-cycle pulse whenever o_speed changes
//
// Speed key FSM
//   state  | meaning
//   S_IDLE | speed key released, waiting for a debounced press
//   S_HELD | key held, hold counter running toward a long press
//   S_LONG | long press taken, waiting for release (no increment)
// -----------------------------------------------------------------------------
module rgb_key_ctrl #(
    parameter int DB_CYC   = 1000000,
    parameter int LONG_CYC = 50000000,
    parameter int BASE_DIV = 250000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_spd_n,
    input  logic       i_key_mode_n,
    output logic [1:0] o_speed,
    output logic [1:0] o_mode,
    output logic       o_step_tick,
    output logic       o_spd_evt
);

    localparam int          K_SPD     = 0;
    localparam int          K_MODE    = 1;
    localparam logic [31:0] DB_LAST   = 32'(DB_CYC - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_LONG = 2'd2
    } state_t;

    logic [1:0]  w_key_raw;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_db;
    logic [31:0] r_db_cnt [2];
    logic [1:0]  w_acc;
    logic [1:0]  w_press;
    logic [1:0]  w_rel;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_hold;
    logic [31:0] w_hold_next;
    logic [1:0]  r_speed;
    logic [1:0]  w_speed_next;
    logic        w_spd_chg;
    logic        r_spd_evt;

    logic [1:0]  r_mode;

    logic [31:0] r_tick_cnt;
    logic [31:0] w_tick_cnt_next;
    logic [31:0] w_tick_last;
    logic        r_tick;

    assign w_key_raw = {i_key_mode_n, i_key_spd_n};

    // Acceptance is decoded from the current counter so that the debounced
    // state and the events it triggers update on the same edge.
    always_comb begin
        w_acc   = '0;
        w_press = '0;
        w_rel   = '0;
        for (int k = 0; k < 2; k++) begin
            w_acc[k]   = (r_sync2[k] != r_db[k]) && (r_db_cnt[k] == DB_LAST);
            w_press[k] = w_acc[k] && !r_sync2[k];
            w_rel[k]   = w_acc[k] && r_sync2[k];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db    <= '1;
            for (int k = 0; k < 2; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (w_acc[k]) begin
                    r_db[k]     <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode <= 2'b00;
        end else if (w_press[K_MODE]) begin
            case (r_mode)
                2'b00:   r_mode <= 2'b01;
                2'b01:   r_mode <= 2'b10;
                default: r_mode <= 2'b00;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_hold    <= '0;
            r_speed   <= 2'b01;
            r_spd_evt <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_hold    <= w_hold_next;
            r_speed   <= w_speed_next;
            r_spd_evt <= w_spd_chg;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_speed_next = r_speed;
        w_spd_chg    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press[K_SPD]) begin
                    w_state_next = S_HELD;
                    w_hold_next  = '0;
                end
            end
            S_HELD: begin
                // Release wins over the long-press threshold in the same cycle.
                if (w_rel[K_SPD]) begin
                    w_speed_next = r_speed + 2'd1;
                    w_spd_chg    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_hold == LONG_LAST) begin
                    w_speed_next = 2'b01;
                    w_spd_chg    = (r_speed != 2'b01);
                    w_state_next = S_LONG;
                end else begin
                    w_hold_next = r_hold + 32'd1;
                end
            end
            S_LONG: begin
                if (w_rel[K_SPD]) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Period is BASE_DIV << (3 - speed); a speed change restarts the count
    // and suppresses any tick that would have landed on that edge.
    assign w_tick_last = (32'(BASE_DIV) << (2'd3 - r_speed)) - 32'd1;

    always_comb begin
        w_tick_cnt_next = r_tick_cnt + 32'd1;
        if (w_spd_chg || (r_tick_cnt >= w_tick_last)) begin
            w_tick_cnt_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick_cnt_next;
            r_tick     <= !w_spd_chg && (w_tick_cnt_next == w_tick_last);
        end
    end

    assign o_speed     = r_speed;
    assign o_mode      = r_mode;
    assign o_step_tick = r_tick;
    assign o_spd_evt   = r_spd_evt;

endmodule

// File: tb/tb_rgb_key_ctrl.sv
module tb_rgb_key_ctrl;

    logic       clk;
    logic       rst;
    logic       key_spd_n;
    logic       key_mode_n;
    logic [1:0] speed;
    logic [1:0] mode;
    logic       step_tick;
    logic       spd_evt;

    int total = 0;
    int bad   = 0;

    int cyc         = 0;
    int evt_cnt     = 0;
    int evt_cyc     = -1;
    int prev_tick   = -1;
    int last_period = -1;
    int gap         = -1;

    rgb_key_ctrl #(
        .DB_CYC  (4),
        .LONG_CYC(20),
        .BASE_DIV(4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_key_spd_n (key_spd_n),
        .i_key_mode_n(key_mode_n),
        .o_speed     (speed),
        .o_mode      (mode),
        .o_step_tick (step_tick),
        .o_spd_evt   (spd_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sel;     // 0 = speed key, 1 = mode key
        int low;     // cycles the raw key is held low
        int exp_mode;
        int exp_spd;
        int exp_evts;
        int exp_period;
        int exp_gap; // cycles from SPD_EVT cycle to first tick (P-1)
    } vec_t;

    vec_t vecs [16];

    // Advance one clock, sample 1 time unit after the edge, track events.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (spd_evt === 1'b1) begin
            evt_cnt++;
            evt_cyc     = cyc;
            prev_tick   = -1;
            last_period = -1;
            gap         = -1;
        end
        if (step_tick === 1'b1) begin
            if (gap < 0 && evt_cyc >= 0) gap = cyc - evt_cyc;
            if (prev_tick >= 0) last_period = cyc - prev_tick;
            prev_tick = cyc;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        int first_tick;
        int second_tick;

        //            sel low mode spd evts per gap
        vecs[0]  = '{1,  3,  0,  1,  0,  16, 0};
        vecs[1]  = '{1, 10,  1,  1,  0,  16, 0};
        vecs[2]  = '{1, 10,  2,  1,  0,  16, 0};
        vecs[3]  = '{1, 10,  0,  1,  0,  16, 0};
        vecs[4]  = '{1, 10,  1,  1,  0,  16, 0};
        vecs[5]  = '{1,  2,  1,  1,  0,  16, 0};
        vecs[6]  = '{1,  4,  2,  1,  0,  16, 0};
        vecs[7]  = '{1, 10,  0,  1,  0,  16, 0};
        vecs[8]  = '{1, 10,  1,  1,  0,  16, 0};
        vecs[9]  = '{0,  3,  1,  1,  0,  16, 0};
        vecs[10] = '{0, 10,  1,  2,  1,   8, 7};
        vecs[11] = '{0, 10,  1,  3,  1,   4, 3};
        vecs[12] = '{0, 10,  1,  0,  1,  32, 31};
        vecs[13] = '{0,  4,  1,  1,  1,  16, 15};
        vecs[14] = '{0, 10,  1,  2,  1,   8, 7};
        vecs[15] = '{0, 10,  1,  3,  1,   4, 3};

        rst        = 1'b1;
        key_spd_n  = 1'b1;
        key_mode_n = 1'b1;
        steps(3);
        chk("reset_speed", speed, 1);
        chk("reset_mode", mode, 0);
        chk("reset_tick", step_tick, 0);
        chk("reset_evt", spd_evt, 0);

        // First tick lands after the 15th edge following the last reset edge.
        rst = 1'b0;
        cyc = 0;
        first_tick  = -1;
        second_tick = -1;
        for (int k = 1; k <= 31; k++) begin
            step();
            if (step_tick === 1'b1) begin
                if (first_tick < 0) first_tick = k;
                else if (second_tick < 0) second_tick = k;
            end
        end
        chk("first_tick_cycle", first_tick, 15);
        chk("second_tick_cycle", second_tick, 31);
        chk("idle_evt_count", evt_cnt, 0);

        // Exact debounce latency: accepted press visible on the 6th edge.
        key_mode_n = 1'b0;
        steps(5);
        chk("mode_before_accept", mode, 0);
        step();
        chk("mode_at_accept", mode, 1);
        steps(4);
        key_mode_n = 1'b1;
        steps(12);
        // Return to mode 0 so the table starts from a known point.
        key_mode_n = 1'b0;
        steps(10);
        key_mode_n = 1'b1;
        steps(12);
        key_mode_n = 1'b0;
        steps(10);
        key_mode_n = 1'b1;
        steps(12);
        chk("mode_wrap_to_0", mode, 0);

        foreach (vecs[v]) begin
            evt_cnt = 0;
            if (vecs[v].sel == 1) key_mode_n = 1'b0;
            else key_spd_n = 1'b0;
            steps(vecs[v].low);
            key_mode_n = 1'b1;
            key_spd_n  = 1'b1;
            steps(80);
            chk($sformatf("vec%0d_mode", v), mode, vecs[v].exp_mode);
            chk($sformatf("vec%0d_speed", v), speed, vecs[v].exp_spd);
            chk($sformatf("vec%0d_evts", v), evt_cnt, vecs[v].exp_evts);
            chk($sformatf("vec%0d_period", v), last_period, vecs[v].exp_period);
            if (vecs[v].exp_evts > 0)
                chk($sformatf("vec%0d_gap", v), gap, vecs[v].exp_gap);
        end

        // Long press from speed 3: press accepted at +6, long reached at +26.
        evt_cnt   = 0;
        key_spd_n = 1'b0;
        steps(25);
        chk("long_speed_before", speed, 3);
        step();
        chk("long_speed_after", speed, 1);
        chk("long_evt_pulse", spd_evt, 1);
        step();
        chk("long_evt_one_cycle", spd_evt, 0);
        steps(20);
        key_spd_n = 1'b1;
        steps(20);
        chk("long_release_speed", speed, 1);
        chk("long_evt_count", evt_cnt, 1);

        // Long press while already at speed 1: no event.
        evt_cnt   = 0;
        key_spd_n = 1'b0;
        steps(40);
        key_spd_n = 1'b1;
        steps(20);
        chk("long_at1_speed", speed, 1);
        chk("long_at1_evts", evt_cnt, 0);

        // Align so the release is accepted on the edge where the count
        // would reach P-1 (P=16, count 0 was the last SPD_EVT cycle).
        for (int i = 0; i < 16 && ((cyc - evt_cyc) % 16) != 15; i++) step();
        chk("align_tick", step_tick, 1);
        key_spd_n = 1'b0;
        steps(10);
        key_spd_n = 1'b1;
        steps(5);
        chk("coll_speed_before", speed, 1);
        step();
        chk("coll_speed", speed, 2);
        chk("coll_evt", spd_evt, 1);
        chk("coll_tick_suppressed", step_tick, 0);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk($sformatf("coll_tick_c%0d", i), step_tick, (i == 7) ? 1 : 0);
        end

        key_spd_n = 1'b0;
        steps(10);
        key_spd_n = 1'b1;
        steps(20);
        chk("pre_rst_speed", speed, 3);
        chk("pre_rst_mode", mode, 1);

        // Reset pulsed with both keys held at MODE=2, SPEED=3.
        key_spd_n  = 1'b0;
        key_mode_n = 1'b0;
        steps(6);
        chk("held_mode", mode, 2);
        chk("held_speed", speed, 3);
        steps(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_speed", speed, 1);
        chk("rst_mode", mode, 0);
        chk("rst_evt", spd_evt, 0);
        evt_cnt = 0;
        steps(5);
        chk("rearm_mode_before", mode, 0);
        step();
        chk("rearm_mode_after", mode, 1);
        steps(30);
        chk("rearm_speed", speed, 1);
        chk("rearm_evts", evt_cnt, 0);
        key_spd_n  = 1'b1;
        key_mode_n = 1'b1;
        steps(20);
        chk("final_mode", mode, 1);
        chk("final_speed", speed, 1);
        chk("final_evts", evt_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
